instr_fetch: RTL

Instruction-fetch initiator driving the synchronous instruction SRAM port: holds the PC, issues one word read per cycle, and absorbs the one-cycle SRAM read latency. Presents `{pc, instr}` to decode with a valid/ready handshake, a one-entry hold buffer for decode stalls, and a zero-bubble redirect for branches, jumps and traps. Sits between the SRAM and the ID stage.

---
 rtl/ifetch_pkg.sv | 11 +
 rtl/ifetch_skid.sv | 40 ++++
 rtl/instr_fetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for instr_fetch (LOAD state only with IFETCH_LOADER_EN)
package ifetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
`ifdef IFETCH_LOADER_EN
    typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif
endpackage

// File: rtl/ifetch_skid.sv
// ifetch_skid: one-entry pc+instr hold buffer used while decode stalls
module ifetch_skid
    import ifetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [XLEN-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               valid,
    output logic [XLEN-1:0]    pc,
    output logic [INSTR_W-1:0] instr
);
    logic               valid_q, valid_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = load | (valid_q & ~clear);
        pc_d    = load ? pc_in : pc_q;
        instr_d = load ? instr_in : instr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, SRAM read issue and valid/ready fetch output; loader port under IFETCH_LOADER_EN
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               instr_sram_en,
    output logic               instr_sram_we,
    output logic [XLEN-1:0]    instr_sram_addr,
    output logic [INSTR_W-1:0] instr_sram_wdata,
    input  logic [INSTR_W-1:0] instr_sram_rdata,
`ifdef IFETCH_LOADER_EN
    input  logic               load_en,
    input  logic [XLEN-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_wdata,
`endif
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
);
    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]    resp_pc_q, resp_pc_d;
    logic               hold_valid, hold_load, hold_clear;
    logic [XLEN-1:0]    hold_pc, addr;
    logic [INSTR_W-1:0] hold_instr;
    logic               stall, issue, load_st;
    logic [XLEN-1:0]    ld_addr;
    logic [INSTR_W-1:0] ld_wdata;

`ifdef IFETCH_LOADER_EN
    logic [XLEN-1:0]    ld_addr_q;
    logic [INSTR_W-1:0] ld_wdata_q;
    assign load_st  = state_q == LOAD;
    assign state_d  = load_en ? LOAD : RUN;
    assign ld_addr  = ld_addr_q;
    assign ld_wdata = ld_wdata_q;

    // Loader write is registered so it lands on the SRAM the cycle after load_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_addr_q  <= '0;
            ld_wdata_q <= '0;
        end else if (load_en) begin
            ld_addr_q  <= load_addr & ~32'h3;
            ld_wdata_q <= load_wdata;
        end
    end
`else
    assign load_st  = 1'b0;
    assign state_d  = RUN;
    assign ld_addr  = '0;
    assign ld_wdata = '0;
`endif

    always_comb begin
        if_valid     = ~redirect_valid & ~load_st & (hold_valid | resp_valid_q);
        stall        = if_valid & ~id_ready;
        addr         = redirect_valid ? (redirect_pc & ~32'h3) : pc_q;
        issue        = (state_q == RUN) & (redirect_valid | ~stall);
        pc_d         = load_st ? RESET_PC : issue ? addr + PC_STEP : pc_q;
        resp_valid_d = issue;
        resp_pc_d    = issue ? addr : resp_pc_q;
        hold_load    = resp_valid_q & ~hold_valid & stall;
        hold_clear   = id_ready | redirect_valid | load_st;
        if_pc        = hold_valid ? hold_pc : resp_pc_q;
        if_instr     = hold_valid ? hold_instr : instr_sram_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
        end
    end

    ifetch_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .clear    (hold_clear),
        .pc_in    (resp_pc_q),
        .instr_in (instr_sram_rdata),
        .valid    (hold_valid),
        .pc       (hold_pc),
        .instr    (hold_instr)
    );

    assign instr_sram_en    = issue | load_st;
    assign instr_sram_we    = load_st;
    assign instr_sram_addr  = load_st ? ld_addr : addr;
    assign instr_sram_wdata = load_st ? ld_wdata : '0;
endmodule
